simd_sequencer: RTL

- Parametrised successor to the SIMD instruction decoder: fetches from instruction memory, decodes, and issues PE/dot-product/BRAM controls.
- Adds a start/done handshake, a stall input, nested hardware loops, JUMP and HALT, and illegal-opcode detection.
- Sits between instruction memory and the PE array / dot-product unit / result BRAM write port.

---
 rtl/simd_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/simd_sequencer.sv
// simd_sequencer: fetches from instruction memory, decodes and issues PE,
// dot-product and result-BRAM controls. It supports a start/done handshake,
// a stall input, nested hardware loops, JUMP, HALT and illegal-opcode
// detection.
//
// Optional feature macro: SEQ_PERF_CNT_EN. When it is defined, two saturating
// 32-bit counters are added: issue_count and stall_cycles.
//
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   start               begin execution at pc=0 (accepted in IDLE/HALTED)
//   stall               freeze the current issue slot
//   instruction         {a,b,r,opcode}; valid one cycle after pc
//   pc                  instruction fetch address
//   a_addr/b_addr/r_addr  operand/result addresses, held between issues
//   pe_op, dot_ctrl     PE operation, dot-product control
//   write_en, r_select  BRAM write enable, result source select
//   issue_valid         one-cycle pulse per issued instruction
//   busy, done, err     running, halt pulse, sticky error
//   issue_count, stall_cycles  (SEQ_PERF_CNT_EN only) performance counters
module simd_sequencer #(
    parameter int INS_ADDR_WIDTH = 10,
    parameter int ADDR_WIDTH     = 10,
    parameter int OPCODE_WIDTH   = 4,
    parameter int LOOP_DEPTH     = 2,
    parameter int LOOP_CNT_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic                                  stall,
    input  logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0]  instruction,
    output logic [INS_ADDR_WIDTH-1:0]             pc,
    output logic [ADDR_WIDTH-1:0]                 a_addr,
    output logic [ADDR_WIDTH-1:0]                 b_addr,
    output logic [ADDR_WIDTH-1:0]                 r_addr,
    output logic [1:0]                            pe_op,
    output logic [1:0]                            dot_ctrl,
    output logic                                  write_en,
    output logic                                  r_select,
    output logic                                  issue_valid,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                           issue_count,
    output logic [31:0]                           stall_cycles
`endif
);

    localparam int SPW = $clog2(LOOP_DEPTH + 1);
    // The stack array is sized to a power of two so that the stack pointer
    // width matches the index width exactly. Entries at LOOP_DEPTH and above
    // are never written.
    localparam int STK = 1 << SPW;
    localparam int MW  = (INS_ADDR_WIDTH > ADDR_WIDTH) ? INS_ADDR_WIDTH : ADDR_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL   = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_DSH   = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_DACC  = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_DCLR  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_PASSB = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOOP  = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_ENDL  = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OP_JUMP  = OPCODE_WIDTH'(10);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(15);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;
    state_t state;

    logic [OPCODE_WIDTH-1:0]   op;
    logic [ADDR_WIDTH-1:0]     a_f, b_f, r_f;
    logic [MW-1:0]             a_ext;
    logic [INS_ADDR_WIDTH-1:0] jump_target, pc_inc;

    assign op          = instruction[OPCODE_WIDTH-1:0];
    assign r_f         = instruction[OPCODE_WIDTH +: ADDR_WIDTH];
    assign b_f         = instruction[OPCODE_WIDTH+ADDR_WIDTH +: ADDR_WIDTH];
    assign a_f         = instruction[OPCODE_WIDTH+2*ADDR_WIDTH +: ADDR_WIDTH];
    assign a_ext       = MW'(a_f);
    assign jump_target = a_ext[INS_ADDR_WIDTH-1:0];
    assign pc_inc      = pc + 1'b1;

    // Loop stack
    logic [INS_ADDR_WIDTH-1:0] lp_start [STK];
    logic [LOOP_CNT_WIDTH-1:0] lp_cnt   [STK];
    logic [SPW-1:0]            sp, top;
    logic                      stk_full, stk_empty;

    assign top       = sp - SPW'(1);
    assign stk_full  = (sp == SPW'(LOOP_DEPTH));
    assign stk_empty = (sp == '0);

    // Decode of the datapath controls
    logic [1:0] dec_pe, dec_dot;
    logic       dec_we, dec_rsel, dec_illegal;

    always_comb begin
        dec_pe      = 2'b00;
        dec_dot     = 2'b00;
        dec_we      = 1'b0;
        dec_rsel    = 1'b0;
        dec_illegal = 1'b0;
        case (op)
            OP_NOP:   ;
            OP_ADD:   begin dec_pe = 2'b01; dec_we = 1'b1; end
            OP_SUB:   begin dec_pe = 2'b10; dec_we = 1'b1; end
            OP_MUL:   begin dec_pe = 2'b11; dec_we = 1'b1; end
            OP_DSH:   begin dec_pe = 2'b11; dec_dot = 2'b01; dec_we = 1'b1; dec_rsel = 1'b1; end
            OP_DACC:  begin dec_pe = 2'b11; dec_dot = 2'b10; dec_we = 1'b1; dec_rsel = 1'b1; end
            OP_DCLR:  dec_dot = 2'b11;
            OP_PASSB: dec_we = 1'b1;
            OP_LOOP, OP_ENDL, OP_JUMP, OP_HALT: ;
            default:  dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            pc          <= '0;
            a_addr      <= '0;
            b_addr      <= '0;
            r_addr      <= '0;
            pe_op       <= 2'b00;
            dot_ctrl    <= 2'b00;
            write_en    <= 1'b0;
            r_select    <= 1'b0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            sp          <= '0;
            for (int i = 0; i < STK; i++) begin
                lp_start[i] <= '0;
                lp_cnt[i]   <= '0;
            end
        end else begin
            // Pulsed controls. dot_ctrl also returns to off so that the
            // dot-product unit never sees a command for more than one cycle.
            issue_valid <= 1'b0;
            write_en    <= 1'b0;
            done        <= 1'b0;
            dot_ctrl    <= 2'b00;
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state <= FETCH;
                        pc    <= '0;
                        err   <= 1'b0;
                        sp    <= '0;
                        busy  <= 1'b1;
                    end
                end
                FETCH: state <= ISSUE;
                ISSUE: begin
                    if (!stall) begin
                        issue_valid <= 1'b1;
                        a_addr      <= a_f;
                        b_addr      <= b_f;
                        r_addr      <= r_f;
                        pe_op       <= dec_pe;
                        dot_ctrl    <= dec_dot;
                        write_en    <= dec_we;
                        r_select    <= dec_rsel;
                        state       <= FETCH;
                        pc          <= pc_inc;
                        case (op)
                            OP_LOOP: begin
                                if (stk_full) begin
                                    err <= 1'b1;
                                end else begin
                                    lp_start[sp] <= pc_inc;
                                    lp_cnt[sp]   <= r_f[LOOP_CNT_WIDTH-1:0];
                                    sp           <= sp + SPW'(1);
                                end
                            end
                            OP_ENDL: begin
                                if (stk_empty) begin
                                    err <= 1'b1;
                                end else if (lp_cnt[top] > LOOP_CNT_WIDTH'(1)) begin
                                    lp_cnt[top] <= lp_cnt[top] - LOOP_CNT_WIDTH'(1);
                                    pc          <= lp_start[top];
                                end else begin
                                    sp <= top;
                                end
                            end
                            OP_JUMP: pc <= jump_target;
                            OP_HALT: begin
                                pc    <= pc;
                                state <= HALTED;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                            default: if (dec_illegal) err <= 1'b1;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            issue_count  <= '0;
            stall_cycles <= '0;
        end else if ((state == IDLE || state == HALTED) && start) begin
            issue_count  <= '0;
            stall_cycles <= '0;
        end else if (state == ISSUE) begin
            if (!stall && issue_count != '1)
                issue_count <= issue_count + 32'd1;
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
